// File: rtl/range_parser.sv
// range_parser
//   Streams ASCII "start-end" pairs ("11-22,95-115,...\n") one byte per cycle,
//   converts each pair to W-bit binary and buffers it in a first-word-fall-through
//   FIFO for the downstream id_finder dispatcher.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high; empties FIFO and drops any partial range
//   in_valid     in_byte / in_last qualify this cycle
//   in_ready     parser can take a byte this cycle
//   in_byte      ASCII character
//   in_last      final byte of the input file
//   out_valid    FIFO head holds a range
//   out_ready    consumer pops the head
//   out_start    head range start (binary), 0 when no head
//   out_end      head range end (binary), 0 when no head
//   range_count  ranges pushed since reset, saturating at 16'hFFFF
//   error        sticky malformed-input / overflow flag
//   done         sticky: last byte taken and FIFO drained

module range_parser #(
    parameter int W     = 48,
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_byte,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_start,
    output logic [W-1:0]  out_end,
    output logic [15:0]   range_count,
    output logic          error,
    output logic          done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_START,
        S_END,
        S_SYNC
    } state_t;

    state_t          state;
    logic [W-1:0]    acc;
    logic [W-1:0]    start_reg;
    logic            digit_seen;
    logic            ovf;
    logic            done_pending;
    logic            error_reg;
    logic            done_reg;
    logic [15:0]     count_reg;

    logic [2*W-1:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    logic            xfer;
    logic            pop;
    logic            push;
    logic [W-1:0]    push_end;

    logic            is_digit;
    logic            is_dash;
    logic            is_term;
    logic            is_skip;
    logic [W+3:0]    acc_ext;
    logic [W+3:0]    acc_next;
    logic            ovf_step;

    // With a power-of-two depth the count MSB is set exactly when the FIFO is full.
    assign fifo_full  = fifo_count[AW];
    assign fifo_empty = (fifo_count == '0);

    // Gated by reset so every output reads 0 while reset is held.
    assign in_ready  = ~reset & ~done_pending & ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign out_start = out_valid ? mem[rd_ptr][2*W-1:W] : '0;
    assign out_end   = out_valid ? mem[rd_ptr][W-1:0]   : '0;

    assign range_count = count_reg;
    assign error       = error_reg;
    assign done        = done_reg;

    assign xfer = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign is_dash  = (in_byte == 8'h2D);
    assign is_term  = (in_byte == 8'h2C) || (in_byte == 8'h0A);
    assign is_skip  = (in_byte == 8'h20) || (in_byte == 8'h0D);

    // acc*10 + digit with four guard bits; anything landing above bit W-1 means
    // the value no longer fits and the range must be rejected.
    assign acc_ext  = {4'b0000, acc};
    assign acc_next = (acc_ext << 3) + (acc_ext << 1) + {{W{1'b0}}, in_byte[3:0]};
    assign ovf_step = |acc_next[W+3:W];

    // Decide whether the byte being taken closes a good range. A closing digit
    // with in_last must push the freshly accumulated value, not the stale acc.
    always_comb begin
        push     = 1'b0;
        push_end = acc;
        if (xfer && state == S_END) begin
            if (is_digit) begin
                if (in_last && !(ovf || ovf_step)) begin
                    push     = 1'b1;
                    push_end = acc_next[W-1:0];
                end
            end else if (is_term || (is_skip && in_last)) begin
                if (digit_seen && !ovf) begin
                    push = 1'b1;
                end
            end
        end
    end

    // Parser FSM. in_last is handled after the per-state decode so that it
    // always wins: the partial range is cleared and the input port closes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_START;
            acc          <= '0;
            start_reg    <= '0;
            digit_seen   <= 1'b0;
            ovf          <= 1'b0;
            done_pending <= 1'b0;
            error_reg    <= 1'b0;
            done_reg     <= 1'b0;
            count_reg    <= '0;
        end else begin
            if (xfer) begin
                case (state)
                    S_START: begin
                        if (is_digit) begin
                            acc        <= acc_next[W-1:0];
                            digit_seen <= 1'b1;
                            ovf        <= ovf | ovf_step;
                            if (in_last) error_reg <= 1'b1;
                        end else if (is_dash) begin
                            if (digit_seen) begin
                                start_reg  <= acc;
                                acc        <= '0;
                                digit_seen <= 1'b0;
                                state      <= S_END;
                                if (in_last) error_reg <= 1'b1;
                            end else begin
                                error_reg <= 1'b1;
                                state     <= S_SYNC;
                            end
                        end else if (is_term) begin
                            if (digit_seen) begin
                                error_reg  <= 1'b1;
                                acc        <= '0;
                                digit_seen <= 1'b0;
                                ovf        <= 1'b0;
                            end
                        end else if (is_skip) begin
                            if (in_last && digit_seen) error_reg <= 1'b1;
                        end else begin
                            error_reg <= 1'b1;
                            state     <= S_SYNC;
                        end
                    end
                    S_END: begin
                        if (is_digit) begin
                            acc        <= acc_next[W-1:0];
                            digit_seen <= 1'b1;
                            ovf        <= ovf | ovf_step;
                            if (in_last && (ovf || ovf_step)) error_reg <= 1'b1;
                        end else if (is_term) begin
                            if (!(digit_seen && !ovf)) error_reg <= 1'b1;
                            acc        <= '0;
                            digit_seen <= 1'b0;
                            ovf        <= 1'b0;
                            state      <= S_START;
                        end else if (is_skip) begin
                            if (in_last && !(digit_seen && !ovf)) error_reg <= 1'b1;
                        end else begin
                            error_reg <= 1'b1;
                            state     <= S_SYNC;
                        end
                    end
                    default: begin
                        if (is_term) begin
                            acc        <= '0;
                            digit_seen <= 1'b0;
                            ovf        <= 1'b0;
                            state      <= S_START;
                        end
                    end
                endcase

                if (in_last) begin
                    acc          <= '0;
                    digit_seen   <= 1'b0;
                    ovf          <= 1'b0;
                    state        <= S_START;
                    done_pending <= 1'b1;
                end
            end

            if (push && count_reg != 16'hFFFF) begin
                count_reg <= count_reg + 16'd1;
            end

            if (done_pending && fifo_empty) begin
                done_reg <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {start_reg, push_end};
        end
    end

endmodule

// File: tb/tb_range_parser.sv
// tb_range_parser
//   Directed bench for range_parser. Expected ranges are queued as each input
//   string is driven and compared against the FIFO head as the DUT pops it.

module tb_range_parser;

    localparam int W     = 48;
    localparam int DEPTH = 8;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_byte;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_start;
    logic [W-1:0]  out_end;
    logic [15:0]   range_count;
    logic          error;
    logic          done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2*W-1:0] exp_q[$];

    range_parser #(.W(W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_start   (out_start),
        .out_end     (out_end),
        .range_count (range_count),
        .error       (error),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [2*W-1:0] observed,
                               input logic [2*W-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive one byte and hold it until in_ready lets it through (bounded).
    task automatic applyStimulus(input logic [7:0] b, input logic l);
        bit accepted;
        int cycles;
        accepted = 0;
        cycles   = 0;
        in_byte  = b;
        in_last  = l;
        in_valid = 1'b1;
        while (!accepted && cycles < 200) begin
            @(negedge clock);
            if (in_ready) accepted = 1;
            @(posedge clock);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!accepted) checkOutput("in_ready timeout", '0, 1);
    endtask

    task automatic send_string(input string s, input bit last_on_final);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i], last_on_final && (i == s.len() - 1));
        end
    endtask

    task automatic expect_range(input logic [W-1:0] s, input logic [W-1:0] e);
        exp_q.push_back({s, e});
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            tick(1);
            c++;
        end
        if (exp_q.size() != 0) checkOutput("drain timeout", exp_q.size(), 0);
        tick(2);
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_byte   = 8'h00;
        reset     = 1'b1;
        #1;
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // Scoreboard: every popped head must match the oldest expected range.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected pop", {out_start, out_end}, '0);
            end else begin
                checkOutput("pop pair", {out_start, out_end}, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        tick(1);

        // Outputs while reset is held
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset out_start", out_start, 0);
        checkOutput("reset count", range_count, 0);
        checkOutput("reset error", error, 0);
        checkOutput("reset done", done, 0);
        reset = 1'b0;
        tick(1);
        checkOutput("idle in_ready", in_ready, 1);

        // Two ranges, consumer always ready
        out_ready = 1'b1;
        expect_range(11, 22);
        expect_range(95, 115);
        send_string("11-22,95-115\n", 1);
        drain();
        tick(2);
        checkOutput("t1 count", range_count, 2);
        checkOutput("t1 error", error, 0);
        checkOutput("t1 done", done, 1);
        checkOutput("t1 in_ready closed", in_ready, 0);

        // Range closed by in_last on a digit; done waits for the pop
        apply_reset();
        out_ready = 1'b0;
        expect_range(998, 1012);
        send_string("998-1012", 1);
        tick(3);
        checkOutput("t2 out_valid", out_valid, 1);
        checkOutput("t2 done early", done, 0);
        out_ready = 1'b1;
        drain();
        tick(1);
        checkOutput("t2 done", done, 1);
        checkOutput("t2 count", range_count, 1);

        // Fill the FIFO, check backpressure and release
        apply_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            expect_range(k, k + 10);
            send_string($sformatf("%0d-%0d,", k, k + 10), 0);
        end
        checkOutput("t3 full in_ready", in_ready, 0);
        checkOutput("t3 full count", range_count, 8);
        out_ready = 1'b1;
        tick(1);
        checkOutput("t3 resume in_ready", in_ready, 1);
        expect_range(9, 19);
        send_string("9-19\n", 1);
        drain();
        checkOutput("t3 count", range_count, 9);
        checkOutput("t3 error", error, 0);
        checkOutput("t3 empty", out_valid, 0);

        // Bad character resyncs at the next terminator
        apply_reset();
        out_ready = 1'b1;
        expect_range(7, 9);
        send_string("1x-5,7-9\n", 1);
        drain();
        checkOutput("t4 error", error, 1);
        checkOutput("t4 count", range_count, 1);

        // Width boundary, overflow, reversed range, embedded spaces
        apply_reset();
        out_ready = 1'b1;
        expect_range(1, 48'hFFFF_FFFF_FFFF);
        expect_range(9, 3);
        expect_range(12, 3);
        send_string("1-281474976710655,", 0);
        tick(1);
        checkOutput("t5 no error at max", error, 0);
        send_string("1-281474976710656,1-9999999999999999999,", 0);
        tick(1);
        checkOutput("t5 overflow error", error, 1);
        send_string("9-3,1 2-3\n", 1);
        drain();
        checkOutput("t5 count", range_count, 3);
        checkOutput("t5 done", done, 1);

        // Reset with buffered entries and an open range
        apply_reset();
        out_ready = 1'b0;
        send_string("1-2,3-4,5-6,7", 0);
        tick(1);
        checkOutput("t6 buffered count", range_count, 3);
        reset = 1'b1;
        #1;
        exp_q.delete();
        checkOutput("t6 reset out_valid", out_valid, 0);
        checkOutput("t6 reset count", range_count, 0);
        checkOutput("t6 reset out_end", out_end, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        out_ready = 1'b1;
        expect_range(5, 6);
        send_string("5-6\n", 1);
        drain();
        checkOutput("t6 count", range_count, 1);
        checkOutput("t6 error", error, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
